rs_issue_scheduler: RTL

RS_ISSUE_SCHEDULER -- requirements
Module: rs_issue_scheduler

---
 rtl/rs_issue_scheduler.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/rs_issue_scheduler.sv
// Reservation station with tag-broadcast wakeup, age-matrix oldest-ready select
// and a single registered issue slot toward the functional unit.
module rs_issue_scheduler #(
    parameter int RS_SIZE      = 8,
    parameter int ROB_IDX_SIZE = 5,
    parameter int GPR_SIZE     = 64
) (
    input  logic                       in_clk,
    input  logic                       in_rst_n,
    input  logic                       in_flush,
    input  logic                       in_alloc_valid,
    output logic                       out_alloc_ready,
    input  logic                       in_alloc_op1_valid,
    input  logic                       in_alloc_op2_valid,
    input  logic [ROB_IDX_SIZE-1:0]    in_alloc_op1_tag,
    input  logic [ROB_IDX_SIZE-1:0]    in_alloc_op2_tag,
    input  logic [GPR_SIZE-1:0]        in_alloc_op1_value,
    input  logic [GPR_SIZE-1:0]        in_alloc_op2_value,
    input  logic [ROB_IDX_SIZE-1:0]    in_alloc_dst,
    input  logic [5:0]                 in_alloc_fu_op,
    input  logic                       in_bcast_valid,
    input  logic [ROB_IDX_SIZE-1:0]    in_bcast_tag,
    input  logic [GPR_SIZE-1:0]        in_bcast_value,
    output logic                       out_issue_valid,
    input  logic                       in_issue_ready,
    output logic [GPR_SIZE-1:0]        out_issue_op1,
    output logic [GPR_SIZE-1:0]        out_issue_op2,
    output logic [ROB_IDX_SIZE-1:0]    out_issue_dst,
    output logic [5:0]                 out_issue_fu_op,
    output logic [$clog2(RS_SIZE):0]   out_count
);
    localparam int CW = $clog2(RS_SIZE) + 1;

    typedef struct packed {
        logic                    op1_v;
        logic [ROB_IDX_SIZE-1:0] op1_tag;
        logic [GPR_SIZE-1:0]     op1_val;
        logic                    op2_v;
        logic [ROB_IDX_SIZE-1:0] op2_tag;
        logic [GPR_SIZE-1:0]     op2_val;
        logic [ROB_IDX_SIZE-1:0] dst;
        logic [5:0]              fu_op;
    } entry_t;

    typedef struct packed {
        logic [GPR_SIZE-1:0]     op1;
        logic [GPR_SIZE-1:0]     op2;
        logic [ROB_IDX_SIZE-1:0] dst;
        logic [5:0]              fu_op;
    } iss_t;

    entry_t                          ent_q [RS_SIZE];
    entry_t                          ent_d [RS_SIZE];
    logic [RS_SIZE-1:0]              busy_q, busy_d;
    // older_q[i][j] set means entry i was allocated before entry j
    logic [RS_SIZE-1:0][RS_SIZE-1:0] older_q, older_d;
    logic [CW-1:0]                   count_q, count_d;
    logic                            iss_valid_q, iss_valid_d;
    iss_t                            iss_q, iss_d;

    logic [RS_SIZE-1:0] rdy, sel, free, alloc_oh;
    logic               issue_load, alloc_fire, found;
    entry_t             new_ent;

    assign out_alloc_ready = (count_q < CW'(RS_SIZE));
    assign issue_load      = !iss_valid_q || in_issue_ready;
    assign alloc_fire      = in_alloc_valid && out_alloc_ready && !in_flush;
    assign free            = issue_load ? sel : '0;

    always_comb begin
        rdy = '0;
        sel = '0;
        for (int i = 0; i < RS_SIZE; i++)
            rdy[i] = busy_q[i] && ent_q[i].op1_v && ent_q[i].op2_v;
        // an entry wins only if no older entry is also ready
        for (int i = 0; i < RS_SIZE; i++) begin
            sel[i] = rdy[i];
            for (int j = 0; j < RS_SIZE; j++)
                if (j != i && rdy[j] && older_q[j][i]) sel[i] = 1'b0;
        end
    end

    always_comb begin
        alloc_oh = '0;
        found    = 1'b0;
        for (int i = 0; i < RS_SIZE; i++)
            if (!busy_q[i] && !found) begin
                alloc_oh[i] = 1'b1;
                found       = 1'b1;
            end
    end

    always_comb begin
        new_ent          = '0;
        new_ent.op1_tag  = in_alloc_op1_tag;
        new_ent.op2_tag  = in_alloc_op2_tag;
        new_ent.dst      = in_alloc_dst;
        new_ent.fu_op    = in_alloc_fu_op;
        new_ent.op1_v    = in_alloc_op1_valid;
        new_ent.op1_val  = in_alloc_op1_value;
        new_ent.op2_v    = in_alloc_op2_valid;
        new_ent.op2_val  = in_alloc_op2_value;
        if (!in_alloc_op1_valid && in_bcast_valid && in_alloc_op1_tag == in_bcast_tag) begin
            new_ent.op1_v   = 1'b1;
            new_ent.op1_val = in_bcast_value;
        end
        if (!in_alloc_op2_valid && in_bcast_valid && in_alloc_op2_tag == in_bcast_tag) begin
            new_ent.op2_v   = 1'b1;
            new_ent.op2_val = in_bcast_value;
        end
    end

    always_comb begin
        ent_d       = ent_q;
        busy_d      = busy_q & ~free;
        older_d     = older_q;
        count_d     = count_q + CW'(alloc_fire) - CW'(|free);
        iss_valid_d = iss_valid_q;
        iss_d       = iss_q;

        for (int i = 0; i < RS_SIZE; i++)
            if (free[i])
                for (int j = 0; j < RS_SIZE; j++) begin
                    older_d[i][j] = 1'b0;
                    older_d[j][i] = 1'b0;
                end

        if (in_bcast_valid)
            for (int i = 0; i < RS_SIZE; i++)
                if (busy_q[i]) begin
                    if (!ent_q[i].op1_v && ent_q[i].op1_tag == in_bcast_tag) begin
                        ent_d[i].op1_v   = 1'b1;
                        ent_d[i].op1_val = in_bcast_value;
                    end
                    if (!ent_q[i].op2_v && ent_q[i].op2_tag == in_bcast_tag) begin
                        ent_d[i].op2_v   = 1'b1;
                        ent_d[i].op2_val = in_bcast_value;
                    end
                end

        for (int i = 0; i < RS_SIZE; i++)
            if (alloc_fire && alloc_oh[i]) begin
                ent_d[i]  = new_ent;
                busy_d[i] = 1'b1;
                for (int j = 0; j < RS_SIZE; j++) begin
                    older_d[j][i] = busy_q[j] && !free[j];
                    older_d[i][j] = 1'b0;
                end
            end

        if (issue_load) begin
            iss_valid_d = |rdy;
            iss_d       = '0;
            for (int i = 0; i < RS_SIZE; i++)
                if (sel[i])
                    iss_d = '{op1: ent_q[i].op1_val, op2: ent_q[i].op2_val,
                              dst: ent_q[i].dst, fu_op: ent_q[i].fu_op};
        end

        if (in_flush) begin
            busy_d      = '0;
            older_d     = '0;
            count_d     = '0;
            iss_valid_d = 1'b0;
            iss_d       = '0;
        end
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            for (int i = 0; i < RS_SIZE; i++) ent_q[i] <= '0;
            busy_q      <= '0;
            older_q     <= '0;
            count_q     <= '0;
            iss_valid_q <= 1'b0;
            iss_q       <= '0;
        end else begin
            for (int i = 0; i < RS_SIZE; i++) ent_q[i] <= ent_d[i];
            busy_q      <= busy_d;
            older_q     <= older_d;
            count_q     <= count_d;
            iss_valid_q <= iss_valid_d;
            iss_q       <= iss_d;
        end
    end

    assign out_issue_valid = iss_valid_q;
    assign out_issue_op1   = iss_q.op1;
    assign out_issue_op2   = iss_q.op2;
    assign out_issue_dst   = iss_q.dst;
    assign out_issue_fu_op = iss_q.fu_op;
    assign out_count       = count_q;

endmodule
